uart_rx_fifo: RTL and testbench

//  Downstream stage of the APB-UART receive path: captures each completed UART Rx byte and its error

---
 rtl/uart_rx_fifo_pkg.sv | 26 ++
 rtl/uart_rx_fifo_if.sv | 23 ++
 rtl/uart_rx_fifo_core.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART Rx FIFO: register offsets, STATUS/CTRL bit positions, entry layout.
package uart_rx_fifo_pkg;

  localparam int unsigned ADDR_DATA   = 'h00;
  localparam int unsigned ADDR_STATUS = 'h04;
  localparam int unsigned ADDR_CTRL   = 'h08;
  localparam int unsigned ADDR_THRESH = 'h0C;

  localparam int unsigned STATUS_OVF_BIT   = 8;
  localparam int unsigned STATUS_FULL_BIT  = 7;
  localparam int unsigned STATUS_EMPTY_BIT = 6;
  localparam int unsigned STATUS_CNT_W     = 6;

  localparam int unsigned CTRL_FLUSH_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned THRESH_W = 5;

  localparam logic [31:0] DATA_EMPTY_WORD = 32'h8000_0000;

  typedef struct packed {
    logic [2:0] err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// APB slave bus bundle for the UART Rx FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned AW = 5
);
  logic          i_psel;
  logic          i_penable;
  logic          i_pwrite;
  logic [AW-1:0] i_paddr;
  logic [31:0]   i_pwdata;
  logic [31:0]   o_prdata;
  logic          o_pready;
  logic          o_pslverr;

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    input  o_prdata, o_pready, o_pslverr
  );

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    output o_prdata, o_pready, o_pslverr
  );
endinterface

// File: rtl/uart_rx_fifo_core.sv
// Synchronous FIFO of Rx entries with push/pop/flush; a push when full is accepted only alongside a pop.
module rx_fifo_core
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  rx_entry_t                  i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output rx_entry_t                  o_head_c,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full_c,
  output logic                       o_empty_c
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rx_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign o_full_c  = (count == CW'(DEPTH));
  assign o_empty_c = (count == '0);
  assign do_pop    = i_pop & ~o_empty_c & ~i_flush;
  assign do_push   = i_push & ~i_flush & (~o_full_c | do_pop);
  assign o_head_c  = mem[rd_ptr];
  assign o_count   = count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART Rx byte FIFO with APB read-pop access; IRQ, irq_en and THRESH exist only when RX_FIFO_IRQ_EN is defined.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic [2:0]         i_rx_error,
  uart_rx_fifo_if.slave      apb,
  output logic               o_irq
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            done_q;
  logic            push;
  logic            access, rd_acc, wr_acc;
  logic            sel_data, sel_status, sel_ctrl, sel_thresh;
  logic            pop, flush, drop, ovf_clr;
  logic            overflow;
  rx_entry_t       head;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            irq_en;
  logic [THRESH_W-1:0] thresh;
  logic [31:0]     prdata_c;
  logic            pslverr_c;
  logic            unused_pwdata;

  assign push       = i_rx_done & ~done_q;
  assign access     = apb.i_psel & apb.i_penable;
  assign rd_acc     = access & ~apb.i_pwrite;
  assign wr_acc     = access & apb.i_pwrite;
  assign sel_data   = (apb.i_paddr == AW'(ADDR_DATA));
  assign sel_status = (apb.i_paddr == AW'(ADDR_STATUS));
  assign sel_ctrl   = (apb.i_paddr == AW'(ADDR_CTRL));
  assign sel_thresh = (apb.i_paddr == AW'(ADDR_THRESH));
  assign pop        = rd_acc & sel_data & ~empty;
  assign flush      = wr_acc & sel_ctrl & apb.i_pwdata[CTRL_FLUSH_BIT];
  assign drop       = push & full & ~pop & ~flush;
  assign ovf_clr    = wr_acc & sel_status & apb.i_pwdata[STATUS_OVF_BIT];
  assign unused_pwdata = ^apb.i_pwdata;

  rx_fifo_core #(.DEPTH(DEPTH)) u_core (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (push),
    .i_wdata   ('{err: i_rx_error, data: i_rx_data}),
    .i_pop     (pop),
    .i_flush   (flush),
    .o_head_c  (head),
    .o_count   (count),
    .o_full_c  (full),
    .o_empty_c (empty)
  );

  // Rising-edge detect on the level done flag plus sticky overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q <= i_rx_done;
      if (flush)        overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef RX_FIFO_IRQ_EN
  logic [THRESH_W-1:0] thresh_eff;
  assign thresh_eff = (thresh == '0) ? THRESH_W'(1) : thresh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_en <= 1'b0;
      thresh <= THRESH_W'(1);
      o_irq  <= 1'b0;
    end else begin
      if (wr_acc && sel_ctrl)   irq_en <= apb.i_pwdata[CTRL_IRQ_EN_BIT];
      if (wr_acc && sel_thresh) thresh <= apb.i_pwdata[THRESH_W-1:0];
      o_irq <= irq_en & ((STATUS_CNT_W'(count) >= STATUS_CNT_W'(thresh_eff)) | overflow);
    end
  end
`else
  assign irq_en = 1'b0;
  assign thresh = '0;
  assign o_irq  = 1'b0;
`endif

  // Zero-wait APB read mux; outputs are forced low outside the access phase.
  always_comb begin
    prdata_c  = '0;
    pslverr_c = 1'b0;
    if (access) begin
      if (sel_data) begin
        if (apb.i_pwrite)  pslverr_c = 1'b1;
        else if (empty)    prdata_c  = DATA_EMPTY_WORD;
        else               prdata_c  = 32'(head);
      end else if (sel_status) begin
        if (!apb.i_pwrite) begin
          prdata_c[STATUS_OVF_BIT]   = overflow;
          prdata_c[STATUS_FULL_BIT]  = full;
          prdata_c[STATUS_EMPTY_BIT] = empty;
          prdata_c[STATUS_CNT_W-1:0] = STATUS_CNT_W'(count);
        end
      end else if (sel_ctrl) begin
        if (!apb.i_pwrite) prdata_c[CTRL_IRQ_EN_BIT] = irq_en;
      end else if (sel_thresh) begin
        if (!apb.i_pwrite) prdata_c[THRESH_W-1:0] = thresh;
      end else begin
        pslverr_c = 1'b1;
      end
    end
  end

  assign apb.o_prdata  = prdata_c;
  assign apb.o_pready  = access;
  assign apb.o_pslverr = pslverr_c;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo; the IRQ section is selected by RX_FIFO_IRQ_EN.
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [2:0] rx_error;
  logic       irq;

  uart_rx_fifo_if #(.AW(5)) apb ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(5)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .i_rx_error (rx_error),
    .apb        (apb),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] sb[$];
  logic        ovf_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = '0;
    s[8] = ovf_exp;
    s[7] = (sb.size() == DEPTH);
    s[6] = (sb.size() == 0);
    s[5:0] = 6'(sb.size());
    return s;
  endfunction

  function automatic void model_push(input logic [10:0] e);
    if (sb.size() < DEPTH) sb.push_back(e);
    else ovf_exp = 1'b1;
  endfunction

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    apb.i_psel = 1'b1; apb.i_penable = 1'b0; apb.i_pwrite = 1'b0; apb.i_paddr = addr;
    @(posedge clk);
    @(negedge clk);
    apb.i_penable = 1'b1;
    #1;
    data = apb.o_prdata;
    err  = apb.o_pslverr;
    check("pready_rd", 32'(apb.o_pready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    apb.i_psel = 1'b0; apb.i_penable = 1'b0;
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] wdata, output logic err);
    @(negedge clk);
    apb.i_psel = 1'b1; apb.i_penable = 1'b0; apb.i_pwrite = 1'b1;
    apb.i_paddr = addr; apb.i_pwdata = wdata;
    @(posedge clk);
    @(negedge clk);
    apb.i_penable = 1'b1;
    #1;
    err = apb.o_pslverr;
    @(posedge clk);
    @(negedge clk);
    apb.i_psel = 1'b0; apb.i_penable = 1'b0; apb.i_pwrite = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic [2:0] e, input int hold);
    @(negedge clk);
    rx_data = d; rx_error = e; rx_done = 1'b1;
    model_push({e, d});
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic read_data_sb(input string tag);
    logic [31:0] d;
    logic        er;
    logic [31:0] exp;
    if (sb.size() == 0) exp = 32'h8000_0000;
    else exp = {21'b0, sb.pop_front()};
    apb_read(5'h00, d, er);
    check(tag, d, exp);
    check({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    logic        er;
    apb_read(5'h04, d, er);
    check(tag, d, status_exp());
  endtask

  initial begin
    logic [31:0] d;
    logic        er;
    logic [31:0] exp;

    rst = 1'b1; rx_data = '0; rx_done = 1'b0; rx_error = '0;
    apb.i_psel = 1'b0; apb.i_penable = 1'b0; apb.i_pwrite = 1'b0;
    apb.i_paddr = '0; apb.i_pwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pready", 32'(apb.o_pready), 32'd0);
    check("rst_prdata", apb.o_prdata, 32'd0);
    check("rst_pslverr", 32'(apb.o_pslverr), 32'd0);
    apb_read(5'h04, d, er);
    check("rst_status", d, 32'h040);
    read_data_sb("empty_data");

    rx_byte(8'hA5, 3'b000, 4);
    read_status("status_one");
    read_data_sb("data_a5");
    read_status("status_after_pop");

    rx_byte(8'h3C, 3'b010, 1);
    read_data_sb("data_3c_err");

    for (int i = 0; i < DEPTH + 1; i++) rx_byte(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1);
    apb_read(5'h04, d, er);
    check("status_ovf_full", d, 32'h190);
    apb_write(5'h04, 32'h100, er);
    check("w1c_err", 32'(er), 32'd0);
    ovf_exp = 1'b0;
    apb_read(5'h04, d, er);
    check("status_w1c", d, 32'h090);

    // Push edge coincides with a DATA pop while full.
    exp = {21'b0, sb.pop_front()};
    @(negedge clk);
    apb.i_psel = 1'b1; apb.i_penable = 1'b0; apb.i_pwrite = 1'b0; apb.i_paddr = 5'h00;
    @(posedge clk);
    @(negedge clk);
    apb.i_penable = 1'b1;
    rx_data = 8'h5E; rx_error = 3'b001; rx_done = 1'b1;
    model_push({3'b001, 8'h5E});
    #1;
    check("full_pushpop_data", apb.o_prdata, exp);
    @(posedge clk);
    @(negedge clk);
    apb.i_psel = 1'b0; apb.i_penable = 1'b0; rx_done = 1'b0;
    read_status("status_full_pushpop");

    for (int i = 0; i < DEPTH; i++) read_data_sb("drain");
    read_status("status_drained");
    read_data_sb("drained_empty");

    apb_read(5'h10, d, er);
    check("bad_addr_data", d, 32'd0);
    check("bad_addr_err", 32'(er), 32'd1);
    apb_write(5'h00, 32'h55, er);
    check("data_write_err", 32'(er), 32'd1);
    read_status("status_after_bad");

    for (int i = 0; i < DEPTH + 2; i++) rx_byte(8'(i), 3'b000, 2);
    read_status("status_pre_flush");
    apb_write(5'h08, 32'h1, er);
    sb.delete();
    ovf_exp = 1'b0;
    read_status("status_flush");
    read_data_sb("flush_empty");

`ifdef RX_FIFO_IRQ_EN
    apb_write(5'h0C, 32'd3, er);
    apb_write(5'h08, 32'h2, er);
    apb_read(5'h0C, d, er);
    check("thresh_rd", d, 32'd3);
    apb_read(5'h08, d, er);
    check("ctrl_rd", d, 32'h2);
    rx_byte(8'h11, 3'b000, 1);
    rx_byte(8'h22, 3'b000, 1);
    check("irq_two", 32'(irq), 32'd0);
    @(negedge clk);
    rx_data = 8'h33; rx_error = 3'b000; rx_done = 1'b1;
    model_push({3'b000, 8'h33});
    @(posedge clk); #1;
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    rx_done = 1'b0;
    @(posedge clk); #1;
    check("irq_set", 32'(irq), 32'd1);
    read_data_sb("irq_pop");
    @(posedge clk); #1;
    check("irq_clr", 32'(irq), 32'd0);
    apb_write(5'h08, 32'h1, er);
    sb.delete();
    read_status("irq_flush_status");
`else
    apb_write(5'h08, 32'h2, er);
    check("ctrl_w_err", 32'(er), 32'd0);
    apb_write(5'h0C, 32'd3, er);
    check("thresh_w_err", 32'(er), 32'd0);
    apb_read(5'h08, d, er);
    check("ctrl_rd_off", d, 32'd0);
    apb_read(5'h0C, d, er);
    check("thresh_rd_off", d, 32'd0);
    for (int i = 0; i < 4; i++) rx_byte(8'(8'h40 + i), 3'b100, 1);
    @(posedge clk); #1;
    check("irq_off", 32'(irq), 32'd0);
    read_data_sb("off_data0");
    read_status("off_status");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
